// File: rtl/alu_muldiv_seq.sv
// Execute unit: single-cycle base integer ALU plus iterative radix-2 multiply/divide (RV32M/RV64M).
// Valid/ready handshake on both sides; special-case M ops complete in a single cycle.
module alu_muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned CntW = ShW;
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpAnd  = 5'b00010;
  localparam logic [4:0] OpOr   = 5'b00011;
  localparam logic [4:0] OpXor  = 5'b00100;
  localparam logic [4:0] OpSll  = 5'b00101;
  localparam logic [4:0] OpSrl  = 5'b00110;
  localparam logic [4:0] OpSra  = 5'b00111;
  localparam logic [4:0] OpSlt  = 5'b01000;
  localparam logic [4:0] OpSltu = 5'b01001;
  localparam logic [4:0] OpDiv  = 5'b10100;
  localparam logic [4:0] OpDivu = 5'b10101;
  localparam logic [4:0] OpRem  = 5'b10110;
  localparam logic [4:0] OpRemu = 5'b10111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic [XLEN:0]     hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [4:0]        op_q, op_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic              accept;
  logic              is_mul, is_div, div_signed, b_zero, div_ovf, special, slow;
  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [ShW-1:0]    shamt;
  logic [XLEN-1:0]   fast_res;
  logic              last;

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [XLEN:0]     step_hi;
  logic [XLEN-1:0]   step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, fin_res;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  assign accept     = in_valid && in_ready;
  assign is_mul     = (in_op[4:2] == 3'b100);
  assign is_div     = (in_op[4:2] == 3'b101);
  assign div_signed = ~in_op[0];
  assign b_zero     = (in_b == '0);
  assign div_ovf    = div_signed && (in_a == MinVal) && (in_b == '1);
  assign special    = is_div && (b_zero || div_ovf);
  assign slow       = (is_mul || is_div) && !special;
  assign shamt      = in_b[ShW-1:0];

  // Operand signedness: MULH signs both, MULHSU only A, MUL/MULHU neither.
  assign a_sgn = in_a[XLEN-1] &&
                 ((is_mul && (in_op[1:0] == 2'b01 || in_op[1:0] == 2'b10)) ||
                  (is_div && div_signed));
  assign b_sgn = in_b[XLEN-1] &&
                 ((is_mul && in_op[1:0] == 2'b01) || (is_div && div_signed));
  assign a_mag = a_sgn ? (~in_a + 1'b1) : in_a;
  assign b_mag = b_sgn ? (~in_b + 1'b1) : in_b;

  always_comb begin
    fast_res = '0;
    case (in_op)
      OpAdd:  fast_res = in_a + in_b;
      OpSub:  fast_res = in_a - in_b;
      OpAnd:  fast_res = in_a & in_b;
      OpOr:   fast_res = in_a | in_b;
      OpXor:  fast_res = in_a ^ in_b;
      OpSll:  fast_res = in_a << shamt;
      OpSrl:  fast_res = in_a >> shamt;
      OpSra:  fast_res = $unsigned($signed(in_a) >>> shamt);
      OpSlt:  fast_res[0] = ($signed(in_a) < $signed(in_b));
      OpSltu: fast_res[0] = (in_a < in_b);
      OpDiv, OpDivu: fast_res = b_zero ? '1 : in_a;
      OpRem, OpRemu: fast_res = b_zero ? in_a : '0;
      default: fast_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative datapath: shift-add multiply / restoring divide on magnitudes
  // ---------------------------------------------------------------------------
  always_comb begin
    mul_sum   = lo_q[0] ? (hi_q + {1'b0, opd_q}) : hi_q;
    div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    div_ge    = (div_shift >= {1'b0, opd_q});
    if (!op_q[2]) begin
      step_hi = {1'b0, mul_sum[XLEN:1]};
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end else begin
      step_hi = div_ge ? div_diff : div_shift;
      step_lo = {lo_q[XLEN-2:0], div_ge};
    end
  end

  assign last = (cnt_q == CntW'(XLEN - 1));

  always_comb begin
    prod   = {step_hi[XLEN-1:0], step_lo};
    prod_s = neg_quo_q ? (~prod + 1'b1) : prod;
    quo    = neg_quo_q ? (~step_lo + 1'b1) : step_lo;
    rem    = neg_rem_q ? (~step_hi[XLEN-1:0] + 1'b1) : step_hi[XLEN-1:0];
    case (op_q[2:0])
      3'b000:                 fin_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    opd_d     = opd_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    if (accept && slow) begin
      hi_d      = '0;
      lo_d      = is_mul ? b_mag : a_mag;
      opd_d     = is_mul ? a_mag : b_mag;
      op_d      = in_op;
      neg_quo_d = a_sgn ^ b_sgn;
      neg_rem_d = a_sgn;
      cnt_d     = '0;
    end else if (state_q == StBusy) begin
      hi_d = step_hi;
      lo_d = step_lo;
      if (!last) cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    res_d = res_q;
    tag_d = tag_q;
    if (accept) begin
      tag_d = in_tag;
      if (!slow) res_d = fast_res;
    end else if (state_q == StBusy && last) begin
      res_d = fin_res;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = slow ? StBusy : StDone;
      StBusy: if (last) state_d = StDone;
      StDone: begin
        if (out_ready) begin
          if (accept) state_d = slow ? StBusy : StDone;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    out_valid = (state_q == StDone);
    busy      = (state_q == StBusy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      opd_q     <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      tag_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opd_q     <= opd_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      tag_q     <= tag_d;
    end
  end

  assign out_result = res_q;
  assign out_zero   = (res_q == '0);
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed scenarios plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_muldiv_seq;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [XLEN-1:0]  in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  alu_muldiv_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    logic            ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'(sa >>> b[4:0]);
      5'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  return (a < b) ? 32'd1 : 32'd0;
      5'd16: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      5'd17: begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
      5'd18: begin sp = longint'(sa) * longint'({32'b0, b}); return sp[63:32]; end
      5'd19: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      5'd20: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      5'd23: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic mext, divop, spec;
    mext  = (op >= 5'd16) && (op <= 5'd23);
    divop = (op >= 5'd20) && (op <= 5'd23);
    spec  = divop && ((b == 0) ||
             (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return (mext && !spec) ? XLEN + 1 : 1;
  endfunction

  // Presents one op, waits for acceptance and result, checks latency/result/zero/tag.
  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    logic [31:0] exp;
    int          exp_lat, lat, lim;
    exp     = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    lim = 0;
    while (!in_ready && lim < 100) begin
      @(posedge clk); #1;
      lim++;
    end
    check({name, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op    = 5'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    in_tag   = 5'($urandom);
    if (exp_lat > 1) check({name, " busy"}, busy, 1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, out_result, exp);
    check({name, " zero"}, out_zero, (exp == 0));
    check({name, " tag"}, out_tag, tag);
  endtask

  logic [4:0] legal_ops [18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};

  initial begin
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    logic        stale;
    logic        ok;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_result", out_result, 0);
    check("reset out_zero", out_zero, 1);
    check("reset out_tag", out_tag, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1);

    // Base ops
    do_op("add", 5'd0, 32'd7, 32'd5, 5'd3);
    do_op("sub_zero", 5'd1, 32'd5, 32'd5, 5'd4);
    do_op("sra", 5'd7, 32'h8000_0000, 32'd36, 5'd5);
    do_op("illegal", 5'd12, 32'd9, 32'd9, 5'd6);

    // Multiply
    do_op("mulh", 5'd17, 32'h8000_0000, 32'h8000_0000, 5'd7);
    do_op("mul", 5'd16, 32'h8000_0000, 32'h8000_0000, 5'd8);
    do_op("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);

    // Divide
    do_op("div", 5'd20, -32'sd7, 32'd2, 5'd10);
    do_op("rem", 5'd22, -32'sd7, 32'd2, 5'd11);
    do_op("divu", 5'd21, 32'd100, 32'd7, 5'd12);
    do_op("remu", 5'd23, 32'd100, 32'd7, 5'd13);

    // Special cases
    do_op("divu_by0", 5'd21, 32'd100, 32'd0, 5'd14);
    do_op("remu_by0", 5'd23, 32'd100, 32'd0, 5'd15);
    do_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    do_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);

    // Backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op("bp_divu", 5'd21, 32'd1000, 32'd3, 5'd18);
    held_res = out_result;
    held_tag = out_tag;
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_result !== held_res || out_tag !== held_tag) ok = 1'b0;
    end
    check("bp hold stable", ok, 1);
    check("bp result", out_result, 32'd333);
    in_valid = 1'b1; in_op = 5'd0; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd19;
    out_ready = 1'b1;
    #1;
    check("bp in_ready same cycle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next valid", out_valid, 1);
    check("bp next result", out_result, 32'd2);
    check("bp next tag", out_tag, 5'd19);

    // Reset mid-iteration
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 5'd21; in_a = 32'd5000; in_b = 32'd7; in_tag = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 1);
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("rst no stale result", stale, 0);
    do_op("post_rst_add", 5'd0, 32'd20, 32'd22, 5'd21);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 17)];
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op("rand", rop, ra, rb, 5'($urandom));
    end

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
